systolic_array_feeder: RTL and testbench



---
 rtl/systolic_array_feeder_pkg.sv | 20 ++
 rtl/systolic_array_feeder_buffer.sv | 46 ++++
 rtl/systolic_array_feeder.sv | 152 +++++++++++++++
 tb/tb_systolic_array_feeder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_array_feeder_pkg.sv
// Shared types and helpers for the systolic array operand feeder.
// State encoding, lane count and counter sizing live here.
package pca_feeder_pkg;

    localparam int LANES = 2;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Width able to hold 0..n inclusive.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/systolic_array_feeder_buffer.sv
// K-entry by 2-lane operand store with one diagonally skewed read per lane.
// Lane i reads entry t-i and returns zero outside 0..K-1.
module feed_operand_buffer
    import pca_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int K          = 4,
    parameter int CW         = cnt_w(K)
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [CW-1:0]               waddr,
    input  logic [LANES*DATA_WIDTH-1:0] wdata,
    input  logic [CW-1:0]               t,
    output logic [LANES*DATA_WIDTH-1:0] rdata
);

    localparam int DW = DATA_WIDTH;

    logic [LANES*DW-1:0] mem_q [K];

    always_ff @(posedge clk) begin
        for (int e = 0; e < K; e++) begin
            if (we && waddr == CW'(e)) begin
                mem_q[e] <= wdata;
            end
        end
    end

    always_comb begin
        logic [CW-1:0] ra;
        rdata = '0;
        ra    = '0;
        for (int i = 0; i < LANES; i++) begin
            ra = t - CW'(i);
            if (t >= CW'(i) && ra < CW'(K)) begin
                for (int e = 0; e < K; e++) begin
                    if (ra == CW'(e)) begin
                        rdata[i*DW +: DW] = mem_q[e][i*DW +: DW];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/systolic_array_feeder.sv
// Loads one 2xK A tile and one Kx2 B tile, then replays them skewed
// and zero-padded into a 2x2 systolic array, bracketed by clear and done.
module systolic_array_feeder
    import pca_feeder_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int K            = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [LANES*DATA_WIDTH-1:0] s_a,
    input  logic [LANES*DATA_WIDTH-1:0] s_b,
    output logic [LANES*DATA_WIDTH-1:0] a_feed,
    output logic [LANES*DATA_WIDTH-1:0] b_feed,
    output logic                        array_clr,
    output logic                        busy,
    output logic                        done
);

    localparam int W   = LANES * DATA_WIDTH;
    localparam int CW  = cnt_w(K);
    localparam int DCW = cnt_w(DRAIN_CYCLES);

    state_e         state_q, state_d;
    logic [CW-1:0]  wcnt_q, wcnt_d;
    logic [CW-1:0]  t_q, t_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;

    logic           s_ready_q;
    logic           clr_q;
    logic           busy_q;
    logic           done_q;
    logic [W-1:0]   a_feed_q;
    logic [W-1:0]   b_feed_q;
    logic [W-1:0]   a_rd;
    logic [W-1:0]   b_rd;
    logic           accept;

    assign accept = s_valid && s_ready_q;

    feed_operand_buffer #(
        .DATA_WIDTH(DATA_WIDTH),
        .K         (K),
        .CW        (CW)
    ) u_buf_a (
        .clk  (clk),
        .we   (accept),
        .waddr(wcnt_q),
        .wdata(s_a),
        .t    (t_d),
        .rdata(a_rd)
    );

    feed_operand_buffer #(
        .DATA_WIDTH(DATA_WIDTH),
        .K         (K),
        .CW        (CW)
    ) u_buf_b (
        .clk  (clk),
        .we   (accept),
        .waddr(wcnt_q),
        .wdata(s_b),
        .t    (t_d),
        .rdata(b_rd)
    );

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        t_d     = t_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (wcnt_q == CW'(K - 1)) begin
                        state_d = ST_CLEAR;
                        wcnt_d  = '0;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                state_d = ST_FEED;
                t_d     = '0;
            end
            ST_FEED: begin
                if (t_q == CW'(K)) begin
                    state_d = ST_DRAIN;
                    t_d     = '0;
                    dcnt_d  = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (dcnt_q == DCW'(DRAIN_CYCLES - 1)) begin
                    state_d = ST_DONE;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_LOAD;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_LOAD;
            wcnt_q    <= '0;
            t_q       <= '0;
            dcnt_q    <= '0;
            s_ready_q <= 1'b1;
            clr_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            a_feed_q  <= '0;
            b_feed_q  <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            t_q       <= t_d;
            dcnt_q    <= dcnt_d;
            s_ready_q <= (state_d == ST_LOAD);
            clr_q     <= (state_d == ST_CLEAR);
            busy_q    <= (state_d == ST_CLEAR) ||
                         (state_d == ST_FEED)  ||
                         (state_d == ST_DRAIN);
            done_q    <= (state_d == ST_DONE);
            a_feed_q  <= (state_d == ST_FEED) ? a_rd : '0;
            b_feed_q  <= (state_d == ST_FEED) ? b_rd : '0;
        end
    end

    assign s_ready   = s_ready_q;
    assign array_clr = clr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign a_feed    = a_feed_q;
    assign b_feed    = b_feed_q;

endmodule

// File: tb/tb_systolic_array_feeder.sv
// Directed bench for systolic_array_feeder with a 2x2 array model.
// Checks skew, handshake, timing, reset and end-to-end products.
module tb_systolic_array_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_a = '0;
    logic [15:0] s_b = '0;
    logic [15:0] a_feed;
    logic [15:0] b_feed;
    logic        array_clr;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    logic [15:0] col_a [4] = '{16'h0501, 16'h0602, 16'h0703, 16'h0804};
    logic [15:0] row_b [4] = '{16'h0001, 16'h0100, 16'h0101, 16'h0302};

    systolic_array_feeder #(
        .DATA_WIDTH  (8),
        .K           (4),
        .DRAIN_CYCLES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_a      (s_a),
        .s_b      (s_b),
        .a_feed   (a_feed),
        .b_feed   (b_feed),
        .array_clr(array_clr),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Output-stationary 2x2 array: A flows right, B flows down.
    logic [7:0]  a00, b00, a10, b01;
    logic [31:0] c00, c01, c10, c11;

    always @(posedge clk) begin
        if (rst || array_clr) begin
            a00 <= '0; b00 <= '0; a10 <= '0; b01 <= '0;
            c00 <= '0; c01 <= '0; c10 <= '0; c11 <= '0;
        end else begin
            a00 <= a_feed[7:0];
            b00 <= b_feed[7:0];
            a10 <= a_feed[15:8];
            b01 <= b_feed[15:8];
            c00 <= c00 + 32'(a_feed[7:0]) * 32'(b_feed[7:0]);
            c01 <= c01 + 32'(a00) * 32'(b_feed[15:8]);
            c10 <= c10 + 32'(a_feed[15:8]) * 32'(b00);
            c11 <= c11 + 32'(a10) * 32'(b01);
        end
    end

    // Offers the four beats; returns cycles spent, or -1 on timeout.
    task automatic load_job(input bit gaps, input bit hold,
                            output int ncyc);
        int k = 0;
        int cyc = 0;
        while (k < 4 && cyc < 40) begin
            @(negedge clk);
            s_valid = !(gaps && cyc[0]);
            s_a = col_a[k];
            s_b = row_b[k];
            if (s_valid && s_ready) k++;
            cyc++;
        end
        ncyc = (k == 4) ? cyc : -1;
        @(posedge clk);
        #1;
        if (!hold) s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({s_ready, array_clr, busy, done} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_ctrl got %b want 1000",
                     {s_ready, array_clr, busy, done});
        end
        tests++;
        if ({a_feed, b_feed} !== 32'h0) begin
            fails++;
            $display("FAIL reset_feed got %h want 0", {a_feed, b_feed});
        end
        rst = 1'b0;
    endtask

    task automatic test_skew();
        int n;
        logic [15:0] ea [5] = '{16'h0001, 16'h0502, 16'h0603,
                                16'h0704, 16'h0800};
        logic [15:0] eb [5] = '{16'h0001, 16'h0000, 16'h0101,
                                16'h0102, 16'h0300};
        load_job(1'b0, 1'b0, n);
        tests++;
        if (n !== 4) begin
            fails++;
            $display("FAIL skew_load cycles got %0d want 4", n);
        end
        @(negedge clk);
        tests++;
        if ({array_clr, busy, a_feed, b_feed} !== {2'b11, 32'h0}) begin
            fails++;
            $display("FAIL skew_clear got %b %h want 11 0",
                     {array_clr, busy}, {a_feed, b_feed});
        end
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            tests++;
            if (a_feed !== ea[t]) begin
                fails++;
                $display("FAIL skew_a t=%0d got %h want %h",
                         t, a_feed, ea[t]);
            end
            tests++;
            if (b_feed !== eb[t]) begin
                fails++;
                $display("FAIL skew_b t=%0d got %h want %h",
                         t, b_feed, eb[t]);
            end
        end
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            tests++;
            if ({busy, done, a_feed, b_feed} !== {2'b10, 32'h0}) begin
                fails++;
                $display("FAIL skew_drain d=%0d got %b %h want 10 0",
                         d, {busy, done}, {a_feed, b_feed});
            end
        end
        @(negedge clk);
        tests++;
        if ({busy, done} !== 2'b01) begin
            fails++;
            $display("FAIL skew_done got %b want 01", {busy, done});
        end
        tests++;
        if ({c00, c01, c10, c11} !== {32'd12, 32'd17, 32'd28, 32'd37}) begin
            fails++;
            $display("FAIL psum got %0d %0d %0d %0d want 12 17 28 37",
                     c00, c01, c10, c11);
        end
    endtask

    task automatic test_bubbles();
        int n;
        int bad = 0;
        load_job(1'b1, 1'b1, n);
        tests++;
        if (n !== 7) begin
            fails++;
            $display("FAIL bubble_load cycles got %0d want 7", n);
        end
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (s_ready !== 1'b0) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL backpressure ready-high cycles got %0d want 0",
                     bad);
        end
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL bubble_done got %b want 1", done);
        end
        tests++;
        if ({c00, c01, c10, c11} !== {32'd12, 32'd17, 32'd28, 32'd37}) begin
            fails++;
            $display("FAIL bubble_psum got %0d %0d %0d %0d want 12 17 28 37",
                     c00, c01, c10, c11);
        end
        s_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({s_ready, done} !== 2'b10) begin
            fails++;
            $display("FAIL bubble_reload got %b want 10", {s_ready, done});
        end
    endtask

    task automatic test_timing();
        int n;
        for (int job = 0; job < 2; job++) begin
            load_job(1'b0, 1'b0, n);
            tests++;
            if (n !== 4) begin
                fails++;
                $display("FAIL timing_load job=%0d got %0d want 4", job, n);
            end
            for (int c = 1; c <= 9; c++) begin
                @(negedge clk);
                tests++;
                if ({array_clr, busy, done} !==
                    {c == 1, c >= 1 && c <= 8, c == 9}) begin
                    fails++;
                    $display("FAIL timing job=%0d cyc=%0d got %b want %b",
                             job, c, {array_clr, busy, done},
                             {c == 1, c >= 1 && c <= 8, c == 9});
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int n;
        load_job(1'b0, 1'b0, n);
        repeat (4) @(negedge clk);
        tests++;
        if (a_feed !== 16'h0603) begin
            fails++;
            $display("FAIL midrst_t2 got %h want 0603", a_feed);
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({s_ready, array_clr, busy, done, a_feed, b_feed} !==
            {4'b1000, 32'h0}) begin
            fails++;
            $display("FAIL midrst_out got %b %h want 1000 0",
                     {s_ready, array_clr, busy, done}, {a_feed, b_feed});
        end
        rst = 1'b0;
        test_skew();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_skew();
        test_bubbles();
        test_timing();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
